// File: rtl/arb_req_queue_if.sv
// Bundle of handshake signals between one arb_req_queue, its local source,
// the arbiter input it drives and the downstream credit channel.
interface arb_req_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  request;
  logic                  grant;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  credit_return;
  logic [CW-1:0]         credit_count;
  logic                  err;

  // Source, arbiter and downstream side.
  modport master (
    output in_valid, in_data, grant, credit_return,
    input  in_ready, request, out_valid, out_data, credit_count, err
  );

  // Queue side.
  modport slave (
    input  in_valid, in_data, grant, credit_return,
    output in_ready, request, out_valid, out_data, credit_count, err
  );
endinterface

// File: rtl/arb_req_queue.sv
// Requester endpoint for the priority arbiter: DEPTH-entry FIFO that requests while
// it holds data and a downstream credit, and pops one word per grant to a registered output.
module arb_req_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CREDITS    = 4
) (
  input  logic         clk,
  input  logic         rst,
  arb_req_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic full, empty, req, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Request depends on registered state only, so grant can answer combinationally.
  assign req  = !empty && (credit_q != '0);
  assign push = bus.in_valid && !full;
  assign pop  = req && bus.grant;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    credit_d    = credit_q;
    err_d       = err_q;
    out_valid_d = pop;
    out_data_d  = out_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      out_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    // A return with a pop in the same cycle cancels out; a lone surplus return saturates.
    if (bus.credit_return && !pop) begin
      if (credit_q != CRED_MAX) credit_d = credit_q + CW'(1);
    end else if (!bus.credit_return && pop) begin
      credit_d = credit_q - CW'(1);
    end

    if (bus.credit_return && (credit_q == CRED_MAX)) err_d = 1'b1;
    if (bus.grant && !req)                           err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      credit_q    <= CRED_MAX;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: storage is not reset; reset empties the FIFO through the pointers, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_ready     = !full;
  assign bus.request      = req;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.credit_count = credit_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: a cycle model predicts handshake outputs and a
// scoreboard queue holds words expected on out_data, compared when out_valid is due.
module tb_arb_req_queue;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arb_req_queue_if #(.DATA_WIDTH(DW), .CREDITS(CREDITS)) bus ();

  arb_req_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_fifo [$];
  logic [DW-1:0] sb     [$];
  int            m_cred;
  logic          m_err;
  logic          m_ov;
  logic [DW-1:0] m_last;
  logic          follow_grant;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic g, input logic cr);
    logic m_rdy, m_req, m_pop, g_eff;
    m_rdy = (m_fifo.size() < DEPTH);
    m_req = (m_fifo.size() != 0) && (m_cred != 0);
    g_eff = follow_grant ? m_req : g;

    rst               = r;
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.grant         = g_eff;
    bus.credit_return = cr;
    #1;

    check("in_ready",     {31'd0, bus.in_ready},  {31'd0, m_rdy});
    check("request",      {31'd0, bus.request},   {31'd0, m_req});
    check("credit_count", DW'(bus.credit_count),  DW'(m_cred));
    check("err",          {31'd0, bus.err},       {31'd0, m_err});
    check("out_valid",    {31'd0, bus.out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        m_last = sb.pop_front();
        check("out_data", bus.out_data, m_last);
      end
    end else begin
      check("out_data_hold", bus.out_data, m_last);
    end

    if (r) begin
      m_fifo.delete();
      sb.delete();
      m_cred = CREDITS;
      m_err  = 1'b0;
      m_ov   = 1'b0;
      m_last = '0;
    end else begin
      m_pop = m_req && g_eff;
      if (m_pop) sb.push_back(m_fifo.pop_front());
      if (v && m_rdy) m_fifo.push_back(d);
      if (cr && m_cred == CREDITS) m_err = 1'b1;
      if (g_eff && !m_req)         m_err = 1'b1;
      if (cr && !m_pop && m_cred != CREDITS) m_cred++;
      else if (!cr && m_pop)                 m_cred--;
      m_ov = m_pop;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    follow_grant = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.grant         = 1'b0;
    bus.credit_return = 1'b0;
    follow_grant      = 1'b0;
    m_cred = CREDITS;
    m_err  = 1'b0;
    m_ov   = 1'b0;
    m_last = '0;
    rst    = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then a single word with grant tied to request.
    do_reset();
    idle(1);
    follow_grant = 1'b1;
    step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    idle(3);

    // Fill to full with no grants, offer a fifth word, then drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    follow_grant = 1'b1;
    idle(5);

    // Six words against four credits: four pops, stall, one return releases one more.
    do_reset();
    follow_grant = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'hC0DE_0000 + DW'(i), 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // Simultaneous return and pop at count 2, then surplus return at count 4.
    do_reset();
    follow_grant = 1'b1;
    step(1'b0, 1'b1, 32'h1111_0001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h1111_0002, 1'b0, 1'b0);
    follow_grant = 1'b0;
    step(1'b0, 1'b1, 32'h1111_0003, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Grant while empty: no output, sticky error until reset.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3);
    do_reset();
    idle(1);

    // Streaming with pointer wrap, then reset in the middle of traffic.
    follow_grant = 1'b1;
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b1, 32'h5000_0000 + DW'(k), 1'b0, (k >= 2));
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    follow_grant = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
